// File: rtl/solar_tracker_ctrl_pkg.sv
// ============================================================================
// solar_tracker_ctrl_pkg : shared state encodings and default parameters
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package solar_tracker_ctrl_pkg;

  localparam int C_N_AXES      = 2;
  localparam int C_DEB_CYCLES  = 8;
  localparam int C_DEAD_CYCLES = 4;
  localparam int C_TMO_CYCLES  = 1024;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_CW   = 2'd1,
    ST_CCW  = 2'd2,
    ST_DEAD = 2'd3
  } axis_state_t;

endpackage

`default_nettype wire

// File: rtl/solar_tracker_ctrl_if.sv
// ============================================================================
// solar_tracker_ctrl_if : sensor/limit inputs and H-bridge drive outputs
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface solar_tracker_ctrl_if #(
  parameter int N_AXES = 2
);
  logic              en;
  logic [N_AXES-1:0] ld;
  logic [N_AXES-1:0] u;
  logic [N_AXES-1:0] lim_cw;
  logic [N_AXES-1:0] lim_ccw;
  logic [N_AXES-1:0] cw;
  logic [N_AXES-1:0] ccw;
  logic [N_AXES-1:0] busy;
  logic [N_AXES-1:0] fault;

  // master: sensor/switch side driving the controller
  modport master (
    output en, ld, u, lim_cw, lim_ccw,
    input  cw, ccw, busy, fault
  );

  // slave: the controller itself
  modport slave (
    input  en, ld, u, lim_cw, lim_ccw,
    output cw, ccw, busy, fault
  );
endinterface

`default_nettype wire

// File: rtl/solar_tracker_ctrl_limit_debounce.sv
// ============================================================================
// limit_debounce : 2-flop synchroniser plus stability counter, resets to 1
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module limit_debounce #(
  parameter int DEB_CYCLES = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_raw,
  output logic      o_db
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  // Count consecutive samples that disagree with the accepted value;
  // any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 1'b1;
      r_s2  <= 1'b1;
      r_db  <= 1'b1;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 != r_db) begin
        if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_db = r_db;

endmodule

`default_nettype wire

// File: rtl/solar_tracker_ctrl.sv
// ============================================================================
// solar_tracker_ctrl : per-axis LDR tracker motor FSM with debounced end-stops
// and enforced dead-time. Optional stall timeout via `STALL_TIMEOUT_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module solar_tracker_ctrl
  import solar_tracker_ctrl_pkg::*;
#(
  parameter int N_AXES      = C_N_AXES,
  parameter int DEB_CYCLES  = C_DEB_CYCLES,
  parameter int DEAD_CYCLES = C_DEAD_CYCLES,
  parameter int TMO_CYCLES  = C_TMO_CYCLES
) (
  input wire logic            clk,
  input wire logic            rst,
  solar_tracker_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);
`ifdef STALL_TIMEOUT_EN
  localparam int RW = $clog2(TMO_CYCLES + 1);
`endif

  logic [N_AXES-1:0] r_ld_s1;
  logic [N_AXES-1:0] r_ld_s2;
  logic [N_AXES-1:0] r_u_s1;
  logic [N_AXES-1:0] r_u_s2;
  logic [N_AXES-1:0] w_req;
  logic [N_AXES-1:0] w_lim_cw_db;
  logic [N_AXES-1:0] w_lim_ccw_db;
  logic [N_AXES-1:0] w_cw;
  logic [N_AXES-1:0] w_ccw;
  logic [N_AXES-1:0] w_busy;
  logic [N_AXES-1:0] w_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_s1 <= '0;
      r_ld_s2 <= '0;
      r_u_s1  <= '0;
      r_u_s2  <= '0;
    end else begin
      r_ld_s1 <= bus.ld;
      r_ld_s2 <= r_ld_s1;
      r_u_s1  <= bus.u;
      r_u_s2  <= r_u_s1;
    end
  end

  assign w_req = r_ld_s2 | r_u_s2;

  for (genvar a = 0; a < N_AXES; a++) begin : g_axis
    axis_state_t   r_state;
    axis_state_t   w_next;
    logic [DW-1:0] r_dead_cnt;
    logic          w_exit_cw;
    logic          w_exit_ccw;
    logic          w_run_done;
    logic          w_blocked;

    limit_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_cw (
      .clk   (clk),
      .rst   (rst),
      .i_raw (bus.lim_cw[a]),
      .o_db  (w_lim_cw_db[a])
    );

    limit_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_ccw (
      .clk   (clk),
      .rst   (rst),
      .i_raw (bus.lim_ccw[a]),
      .o_db  (w_lim_ccw_db[a])
    );

    assign w_exit_cw  = !bus.en || w_lim_cw_db[a]  || !w_req[a];
    assign w_exit_ccw = !bus.en || w_lim_ccw_db[a] ||  w_req[a];

`ifdef STALL_TIMEOUT_EN
    logic [RW-1:0] r_run_cnt;
    logic          r_fault;

    // Drive has been high TMO_CYCLES cycles when the count hits TMO-1.
    assign w_run_done = (r_run_cnt == RW'(TMO_CYCLES - 1));
    assign w_blocked  = r_fault;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_run_cnt <= '0;
        r_fault   <= 1'b0;
      end else begin
        if (r_state == ST_CW || r_state == ST_CCW) begin
          if (!w_run_done) begin
            r_run_cnt <= r_run_cnt + 1'b1;
          end
        end else begin
          r_run_cnt <= '0;
        end
        if ((r_state == ST_CW  && !w_exit_cw  && w_run_done) ||
            (r_state == ST_CCW && !w_exit_ccw && w_run_done)) begin
          r_fault <= 1'b1;
        end
      end
    end

    assign w_fault[a] = r_fault;
`else
    assign w_run_done = 1'b0;
    assign w_blocked  = 1'b0;
    assign w_fault[a] = 1'b0;
`endif

    always_comb begin
      w_next = r_state;
      case (r_state)
        ST_STOP: begin
          if (bus.en && !w_blocked) begin
            if (w_req[a] && !w_lim_cw_db[a]) begin
              w_next = ST_CW;
            end else if (!w_req[a] && !w_lim_ccw_db[a]) begin
              w_next = ST_CCW;
            end
          end
        end
        ST_CW:   if (w_exit_cw  || w_run_done) w_next = ST_DEAD;
        ST_CCW:  if (w_exit_ccw || w_run_done) w_next = ST_DEAD;
        ST_DEAD: if (r_dead_cnt == DW'(1))     w_next = ST_STOP;
        default: w_next = ST_STOP;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state    <= ST_STOP;
        r_dead_cnt <= '0;
      end else begin
        r_state <= w_next;
        if (w_next == ST_DEAD && r_state != ST_DEAD) begin
          r_dead_cnt <= DW'(DEAD_CYCLES);
        end else if (r_state == ST_DEAD) begin
          r_dead_cnt <= r_dead_cnt - 1'b1;
        end
      end
    end

    assign w_cw[a]   = (r_state == ST_CW);
    assign w_ccw[a]  = (r_state == ST_CCW);
    assign w_busy[a] = (r_state == ST_DEAD);
  end

  assign bus.cw    = w_cw;
  assign bus.ccw   = w_ccw;
  assign bus.busy  = w_busy;
  assign bus.fault = w_fault;

endmodule

`default_nettype wire
